// File: rtl/stack_opcode_sequencer.sv
// Command-side sequencer for the shift-register opcode stack: accepts
// instructions over valid/ready, drives push/pop/wdata, tracks occupancy,
// blocks illegal operations and keeps a sticky first-error code.
module stack_opcode_sequencer #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [2:0]       instr_op,
   input  logic [WIDTH-1:0] instr_imm,
   output logic             stack_push,
   output logic             stack_pop,
   output logic [WIDTH-1:0] stack_wdata,
   input  logic [WIDTH-1:0] stack_rdata,
   output logic [CW-1:0]    depth,
   output logic             carry,
   output logic             error,
   output logic [1:0]       err_code,
   input  logic             err_clear
);

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_PUSH = 3'b001;
   localparam logic [2:0] OP_POP  = 3'b010;
   localparam logic [2:0] OP_DUP  = 3'b011;
   localparam logic [2:0] OP_SWAP = 3'b100;
   localparam logic [2:0] OP_ADD  = 3'b101;
   localparam logic [2:0] OP_CLR  = 3'b110;

   localparam logic [1:0] ERR_OVF = 2'b01;
   localparam logic [1:0] ERR_UDF = 2'b10;
   localparam logic [1:0] ERR_ILL = 2'b11;

   // Opcode is folded into the execution state, so only the immediate is latched.
   typedef enum logic [3:0] {
      S_IDLE, S_SKIP, S_PUSH, S_POP, S_DUP,
      S_SW1, S_SW2, S_SW3, S_SW4,
      S_AD1, S_AD2, S_AD3, S_CLR
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   imm_q, a_q, b_q;
   logic [CW-1:0]      depth_q;
   logic               carry_q, error_q;
   logic [1:0]         err_code_q;
   logic               new_err;
   logic [1:0]         new_code;
   logic               full, empty, lt2;
   logic [WIDTH:0]     sum;

   assign full  = (depth_q >= CW'(DEPTH));
   assign empty = (depth_q == CW'(0));
   assign lt2   = (depth_q <  CW'(2));
   assign sum   = {1'b0, a_q} + {1'b0, b_q};

   // Accept, legality check and execution sequencing.
   always_comb begin
      state_d  = state_q;
      new_err  = 1'b0;
      new_code = 2'b00;
      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               state_d = S_SKIP;
               case (instr_op)
                  OP_NOP:  state_d = S_SKIP;
                  OP_PUSH: if (full) begin new_err = 1'b1; new_code = ERR_OVF; end
                           else state_d = S_PUSH;
                  OP_POP:  if (empty) begin new_err = 1'b1; new_code = ERR_UDF; end
                           else state_d = S_POP;
                  OP_DUP:  if (empty) begin new_err = 1'b1; new_code = ERR_UDF; end
                           else if (full) begin new_err = 1'b1; new_code = ERR_OVF; end
                           else state_d = S_DUP;
                  OP_SWAP: if (lt2) begin new_err = 1'b1; new_code = ERR_UDF; end
                           else state_d = S_SW1;
                  OP_ADD:  if (lt2) begin new_err = 1'b1; new_code = ERR_UDF; end
                           else state_d = S_AD1;
                  OP_CLR:  state_d = S_CLR;
                  default: begin new_err = 1'b1; new_code = ERR_ILL; end
               endcase
            end
         end
         S_SW1:   state_d = S_SW2;
         S_SW2:   state_d = S_SW3;
         S_SW3:   state_d = S_SW4;
         S_AD1:   state_d = S_AD2;
         S_AD2:   state_d = S_AD3;
         S_CLR:   if (depth_q <= CW'(1)) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobe decode from the registered state and latched operands.
   always_comb begin
      stack_push  = 1'b0;
      stack_pop   = 1'b0;
      stack_wdata = '0;
      case (state_q)
         S_PUSH: begin stack_push = 1'b1; stack_wdata = imm_q;       end
         S_DUP:  begin stack_push = 1'b1; stack_wdata = stack_rdata; end
         S_SW3:  begin stack_push = 1'b1; stack_wdata = a_q;         end
         S_SW4:  begin stack_push = 1'b1; stack_wdata = b_q;         end
         S_AD3:  begin stack_push = 1'b1; stack_wdata = sum[WIDTH-1:0]; end
         S_POP, S_SW1, S_SW2, S_AD1, S_AD2: stack_pop = 1'b1;
         S_CLR:  stack_pop = !empty;
         default: ;
      endcase
   end

   // State, operand, occupancy, carry and sticky-error registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         imm_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         depth_q    <= '0;
         carry_q    <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= 2'b00;
      end else begin
         state_q <= state_d;
         if (instr_valid && state_q == S_IDLE) imm_q <= instr_imm;
         if (state_q == S_SW1 || state_q == S_AD1) a_q <= stack_rdata;
         if (state_q == S_SW2 || state_q == S_AD2) b_q <= stack_rdata;
         if (stack_push)     depth_q <= depth_q + CW'(1);
         else if (stack_pop) depth_q <= depth_q - CW'(1);
         if (state_q == S_AD3) carry_q <= sum[WIDTH];
         if (new_err) begin
            error_q <= 1'b1;
            if (!error_q || err_clear) err_code_q <= new_code;
         end else if (err_clear) begin
            error_q    <= 1'b0;
            err_code_q <= 2'b00;
         end
      end
   end

   assign instr_ready = (state_q == S_IDLE);
   assign depth       = depth_q;
   assign carry       = carry_q;
   assign error       = error_q;
   assign err_code    = err_code_q;

endmodule

// File: tb/tb_stack_opcode_sequencer.sv
// Randomized bench for stack_opcode_sequencer against a queue-based
// reference model; a small shift-register stack closes the loop.
module tb_stack_opcode_sequencer;

   logic       clock, reset;
   logic       instr_valid, instr_ready;
   logic [2:0] instr_op;
   logic [3:0] instr_imm;
   logic       stack_push, stack_pop;
   logic [3:0] stack_wdata, stack_rdata;
   logic [4:0] depth;
   logic       carry, error;
   logic [1:0] err_code;
   logic       err_clear;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: stack contents (index 0 = top) and status.
   int         mstk[$];
   bit         merr;
   logic [1:0] mcode;
   bit         mcarry;

   logic [3:0] smem [16];

   stack_opcode_sequencer #(.DEPTH(16), .WIDTH(4)) dut (
      .clock(clock), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_imm(instr_imm),
      .stack_push(stack_push), .stack_pop(stack_pop),
      .stack_wdata(stack_wdata), .stack_rdata(stack_rdata),
      .depth(depth), .carry(carry), .error(error),
      .err_code(err_code), .err_clear(err_clear)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Driven stack: shift register, zero refill at the bottom on pop.
   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) smem[i] <= 4'h0;
      end else if (stack_push) begin
         for (int i = 15; i > 0; i--) smem[i] <= smem[i-1];
         smem[0] <= stack_wdata;
      end else if (stack_pop) begin
         for (int i = 0; i < 15; i++) smem[i] <= smem[i+1];
         smem[15] <= 4'h0;
      end
   end
   assign stack_rdata = smem[0];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] step(input bit push, input bit pop, input int wd);
      return {1'b0, push, pop, 4'(wd)};
   endfunction

   task automatic check_idle(input string tag);
      check_eq({tag, "_bus"},  {instr_ready, stack_push, stack_pop, stack_wdata}, {1'b1, 1'b0, 1'b0, 4'h0});
      check_eq({tag, "_depth"}, 32'(depth), 32'(mstk.size()));
      check_eq({tag, "_carry"}, 32'(carry), 32'(mcarry));
      check_eq({tag, "_error"}, 32'(error), 32'(merr));
      check_eq({tag, "_code"},  32'(err_code), 32'(mcode));
      check_eq({tag, "_top"},   32'(stack_rdata), (mstk.size() > 0) ? 32'(mstk[0]) : 32'd0);
   endtask

   task automatic model_reset();
      mstk.delete();
      merr = 1'b0; mcode = 2'b00; mcarry = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; instr_valid = 1'b0; err_clear = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      check_idle("reset");
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      @(negedge clock);
      err_clear = 1'b0;
      merr = 1'b0; mcode = 2'b00;
      check_idle("clear");
   endtask

   // Issue one instruction, then check every execution cycle and the end state.
   task automatic do_op(input logic [2:0] op, input logic [3:0] imm, input bit clr);
      logic [6:0] exp_q[$];
      int n, a, b, s, t;
      logic [1:0] ncode;
      t = 0;
      while (!instr_ready && t < 20) begin @(negedge clock); t++; end
      if (!instr_ready) begin check_eq("ready_wait", 32'(instr_ready), 32'd1); return; end
      n = mstk.size(); ncode = 2'b00;
      case (op)
         3'd0: exp_q.push_back(step(0, 0, 0));
         3'd1: if (n >= 16) ncode = 2'b01;
               else begin exp_q.push_back(step(1, 0, imm)); mstk.push_front(int'(imm)); end
         3'd2: if (n < 1) ncode = 2'b10;
               else begin exp_q.push_back(step(0, 1, 0)); void'(mstk.pop_front()); end
         3'd3: if (n < 1) ncode = 2'b10;
               else if (n >= 16) ncode = 2'b01;
               else begin exp_q.push_back(step(1, 0, mstk[0])); mstk.push_front(mstk[0]); end
         3'd4: if (n < 2) ncode = 2'b10;
               else begin
                  a = mstk.pop_front(); b = mstk.pop_front();
                  exp_q.push_back(step(0, 1, 0)); exp_q.push_back(step(0, 1, 0));
                  exp_q.push_back(step(1, 0, a)); exp_q.push_back(step(1, 0, b));
                  mstk.push_front(a); mstk.push_front(b);
               end
         3'd5: if (n < 2) ncode = 2'b10;
               else begin
                  a = mstk.pop_front(); b = mstk.pop_front(); s = a + b;
                  exp_q.push_back(step(0, 1, 0)); exp_q.push_back(step(0, 1, 0));
                  exp_q.push_back(step(1, 0, s % 16));
                  mstk.push_front(s % 16); mcarry = (s >= 16);
               end
         3'd6: if (n == 0) exp_q.push_back(step(0, 0, 0));
               else begin
                  for (int i = 0; i < n; i++) exp_q.push_back(step(0, 1, 0));
                  mstk.delete();
               end
         default: ncode = 2'b11;
      endcase
      if (ncode != 2'b00) begin
         exp_q.push_back(step(0, 0, 0));
         if (!merr || clr) mcode = ncode;
         merr = 1'b1;
      end else if (clr) begin
         merr = 1'b0; mcode = 2'b00;
      end
      instr_valid = 1'b1; instr_op = op; instr_imm = imm; err_clear = clr;
      @(posedge clock);
      #1;
      instr_valid = 1'($urandom_range(0, 1)); instr_op = 3'($urandom);
      instr_imm = 4'($urandom); err_clear = 1'b0;
      foreach (exp_q[i]) begin
         @(negedge clock);
         check_eq($sformatf("op%0d_e%0d", op, i + 1),
                  {instr_ready, stack_push, stack_pop, stack_wdata}, exp_q[i]);
      end
      instr_valid = 1'b0;
      @(negedge clock);
      check_idle($sformatf("op%0d_end", op));
   endtask

   initial begin
      logic [2:0] rop;
      int r;
      reset = 1'b1; instr_valid = 1'b0; instr_op = 3'd0; instr_imm = 4'd0; err_clear = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      do_reset();

      // Basic add, then add with carry.
      do_op(3'd1, 4'd3, 0); do_op(3'd1, 4'd5, 0); do_op(3'd5, 4'd0, 0);
      do_reset();
      do_op(3'd1, 4'd9, 0); do_op(3'd1, 4'd9, 0); do_op(3'd5, 4'd0, 0);

      // Fill to DEPTH, then overflow.
      do_reset();
      for (int k = 0; k < 16; k++) do_op(3'd1, 4'(k), 0);
      do_op(3'd1, 4'd7, 0);
      do_op(3'd3, 4'd0, 0);

      // Underflow, clear, illegal opcode.
      do_reset();
      do_op(3'd2, 4'd0, 0);
      pulse_clear();
      do_op(3'd7, 4'd0, 0);
      do_op(3'd2, 4'd0, 1);

      // Swap then clear.
      do_reset();
      do_op(3'd1, 4'd1, 0); do_op(3'd1, 4'd2, 0); do_op(3'd4, 4'd0, 0);
      do_op(3'd6, 4'd0, 0);
      do_op(3'd6, 4'd0, 0);

      // Reset in the middle of a swap.
      do_reset();
      do_op(3'd1, 4'd4, 0); do_op(3'd1, 4'd6, 0);
      instr_valid = 1'b1; instr_op = 3'd4; instr_imm = 4'd0;
      @(posedge clock);
      #1 instr_valid = 1'b0;
      @(negedge clock);
      check_eq("rst_swap_e1", {instr_ready, stack_push, stack_pop, stack_wdata}, step(0, 1, 0));
      @(negedge clock);
      check_eq("rst_swap_e2", {instr_ready, stack_push, stack_pop, stack_wdata}, step(0, 1, 0));
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      check_idle("rst_swap");
      do_op(3'd3, 4'd0, 0);

      // Randomized phase.
      for (int it = 0; it < 400; it++) begin
         r = $urandom_range(0, 19);
         if (r <= 6 || r >= 18) rop = 3'd1;
         else if (r <= 8)  rop = 3'd2;
         else if (r <= 10) rop = 3'd3;
         else if (r <= 12) rop = 3'd4;
         else if (r <= 14) rop = 3'd5;
         else if (r == 15) rop = 3'd6;
         else if (r == 16) rop = 3'd0;
         else              rop = 3'd7;
         do_op(rop, 4'($urandom), ($urandom_range(0, 7) == 0));
         repeat ($urandom_range(0, 2)) @(negedge clock);
         if ($urandom_range(0, 29) == 0) pulse_clear();
         if ($urandom_range(0, 59) == 0) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/stack_opcode_sequencer.md
Name: stack_opcode_sequencer

Overview:
Command-side initiator for the shift-register opcode stack. It accepts stack instructions over a valid/ready interface and drives the stack's push/pop/write_data strobes. Multi-step operations (DUP, SWAP, ADD, CLR) are sequenced from the stack's top-of-stack read_data. It tracks occupancy, blocks illegal operations, and reports sticky errors. It shares clock and reset with the stack instance it drives.

Parameters:
DEPTH, 16, number of stack entries; must match the driven stack.
WIDTH, 4, data width of stack entries and immediates.
CW, $clog2(DEPTH+1) (5), width of the depth counter.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high.
instr_valid  input  1  instruction present.
instr_ready  output  1  sequencer can accept; high only in IDLE.
instr_op  input  3  opcode: 000 NOP, 001 PUSH, 010 POP, 011 DUP, 100 SWAP, 101 ADD, 110 CLR, 111 illegal.
instr_imm  input  WIDTH  PUSH immediate.
stack_push  output  1  push strobe to stack.
stack_pop  output  1  pop strobe to stack.
stack_wdata  output  WIDTH  data for push; 0 when stack_push is low.
stack_rdata  input  WIDTH  stack top-of-stack (read_data).
depth  output  CW  current occupancy, 0..DEPTH.
carry  output  1  carry-out of last completed ADD.
error  output  1  sticky error flag.
err_code  output  2  first error: 01 overflow, 10 underflow, 11 illegal opcode; 00 none.
err_clear  input  1  clears error/err_code; ignored while reset is high.

Behaviour:
- Reset (synchronous, also mid-operation):
  - State → IDLE; depth=0, carry=0, error=0, err_code=00.
  - stack_push=0, stack_pop=0, stack_wdata=0 from the next cycle.
  - The in-flight instruction is discarded.
- Handshake:
  - Accept on the edge where instr_valid && instr_ready.
  - The opcode and immediate are latched at accept; later instr_* changes are ignored.
  - Execution starts the cycle after accept. No instruction is accepted during execution.
  - Peak throughput is 1 instruction per 2 cycles.
- Strobes: decoded from registered state and latched operands. stack_push and stack_pop are never both high.
- Depth: updates on the same edge as the strobe (+1 push, −1 pop).
- Legality check at accept, from the current depth:
  - PUSH needs depth<DEPTH.
  - POP needs depth≥1.
  - DUP needs 1≤depth<DEPTH.
  - SWAP and ADD need depth≥2.
  - Failing ops: one execution cycle with no strobes, then IDLE. Error is set with code 01 (overflow, i.e. depth==DEPTH for PUSH/DUP) or 10 (underflow).
  - Opcode 111: same handling, code 11.
  - err_code holds the first error until err_clear or reset. error/err_code stay set while a later error occurs.
  - err_clear in the same cycle as a new error: the new error wins.
- Execution sequences (E1 = first cycle after accept); return to IDLE after the last step:
  - NOP: E1 idle.
  - PUSH: E1 push, wdata=imm.
  - POP: E1 pop.
  - DUP: E1 push, wdata=stack_rdata.
  - SWAP: E1 latch a=rdata, pop. E2 latch b=rdata, pop. E3 push a. E4 push b. Final top=b, next=a.
  - ADD: E1 latch a, pop. E2 latch b, pop. E3 push (a+b) mod 2^WIDTH; carry register ← bit WIDTH of a+b at E3.
  - CLR: pop each cycle while depth>0; return to IDLE when depth reaches 0. At depth 0: one cycle with no strobe, no error.
- Arithmetic: unsigned, WIDTH+1-bit sum; the truncated value is pushed.
- The stack bottom refills with 0 on pop; the sequencer never reads below depth, so this value is never consumed.

Test Plan:
- Reset, PUSH 3, PUSH 5, ADD → strobes push(3), push(5), pop, pop, push(8); depth 2→1; stack_rdata=8; carry=0; error=0.
- PUSH 9, PUSH 9, ADD → pushed wdata=2; carry=1; depth=1.
- 16× PUSH k (k=0..15), then PUSH 7 → 17th shows no strobe; error=1, err_code=01; depth=16; top=15.
- From reset, POP → no strobe, err_code=10; then err_clear → error=0, err_code=00; then an illegal op 111 → err_code=11.
- PUSH 1, PUSH 2, SWAP → strobes pop, pop, push(2), push(1); top=1, next=2. Then CLR → exactly 2 pop cycles, depth=0, instr_ready=1.
- PUSH 4, PUSH 6, SWAP with reset asserted at E2 → strobes low the next cycle; depth=0; instr_ready=1; DUP then gives underflow err_code=10.
